seq_detect_prog: RTL and testbench
==================================

# seq_detect_prog

Programmable serial pattern detector: the parametrised successor to the fixed "0011" Moore detector. It samples one serial bit per enabled cycle and compares a shifting history against a runtime-loaded pattern of 1..MAX_LEN bits. It raises a one-cycle registered match pulse, supports overlapping and non-overlapping match modes, and keeps a saturating match counter. It sits on a serial bit stream between the line receiver and the framing/control logic. Out of reset it behaves as the "0011" detector, so existing users need no reconfiguration.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (>=2).
- CNT_W, 8: width of the match counter.
- DEF_PATTERN, 8'b0000_0011: pattern loaded at reset (right-aligned, MAX_LEN bits).
- DEF_LEN, 4: pattern length loaded at reset.
- LW: local, $clog2(MAX_LEN+1).
- clk  in  1  single clock; all logic on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- en  in  1  `in` is valid this cycle.
- in  in  1  serial data bit.
- cfg_load  in  1  load the configuration inputs this cycle.
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; bit [len-1] is the first bit received, bit 0 the last.
- cfg_len  in  LW  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- out  out  1  match pulse, registered.
- match_cnt  out  CNT_W  number of matches since reset or the last load; saturates.
- cfg_err  out  1  the last load had an illegal length; detector is halted.

## Operation
- Registers:
  - hist: MAX_LEN-bit shift register.
  - fill: 0..MAX_LEN, count of valid history bits.
  - pat, len, ovl: active configuration.
  - state: one of {RUN, HALT}.
- Reset (clr=1 at an edge):
  - pat=DEF_PATTERN, len=DEF_LEN, ovl=1.
  - hist=0, fill=0, out=0, match_cnt=0, cfg_err=0, state=RUN.
  - clr overrides all other inputs.
- cfg_load=1 (takes priority over en; the bit presented that cycle is discarded):
  - hist=0, fill=0, out=0, match_cnt=0.
  - If cfg_len is 1..MAX_LEN: latch pat, len and ovl; set cfg_err=0; state=RUN.
  - Otherwise (cfg_len=0 or cfg_len>MAX_LEN): set cfg_err=1 and state=HALT. pat, len and ovl are unchanged.
- RUN with en=1 and no load:
  - hist' = {hist[MAX_LEN-2:0], in}.
  - fill' = min(fill+1, len).
  - hit = (fill' == len) and (hist'[len-1:0] == pat[len-1:0]).
  - On hit:
    - out <= 1.
    - match_cnt <= match_cnt+1, except it holds when already all-ones.
    - If ovl=0, fill <= 0 (hist is still shifted).
  - On no hit: out <= 0.
- RUN with en=0: hist, fill and match_cnt hold; out <= 0.
- HALT: `in` and `en` are ignored; out=0. The only exits are a legal cfg_load or clr.
- Compare mask: bits at or above len are excluded from the comparison.

## Timing
- Latency: when the final pattern bit is sampled at edge k, out is high from edge k to edge k+1. out is exactly one cycle wide per match.
- Back-to-back matches on consecutive enabled bits give out high on consecutive cycles. This requires ovl=1 with a self-overlapping pattern, or len=1.
- match_cnt updates on the same edge that out rises.
- cfg_err updates on the edge that samples cfg_load and holds until the next load or clr.
- Reset mid-pattern: a partially received pattern is lost. The first match after reset needs len fresh enabled bits.
- A new configuration takes effect on the edge after the load. The first possible out is len enabled cycles later, plus one cycle of output latency.

## Test plan
- Reset defaults, en=1, in stream 1,0,0,1,1,0 -> out high only in the cycle after the 5th bit; match_cnt=1; cfg_err=0.
- Load pattern 3'b101, len=3, ovl=1; stream 1,0,1,0,1 -> out pulses after bits 3 and 5; match_cnt=2. Repeat with ovl=0 -> single pulse after bit 3; match_cnt=1.
- Default "0011" stream with en=0 inserted between every bit -> out still pulses once, one cycle after the final 1 is sampled; out=0 during idle cycles; hist unchanged across gaps.
- cfg_load with cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err=1, out stays 0 under any stream. Then load len=1, pat=1, stream 1,1,1 -> cfg_err=0; out high 3 consecutive cycles; match_cnt=3.
- CNT_W=2 build, pattern len=1 pat=0, stream of 5 zeros -> match_cnt 1,2,3,3,3 (saturates); out pulses 5 times.
- clr asserted after 0,0,1 of "0011", then stream 1,0,0,1,1 -> no match on the first 1; a single match after the final 1. Also assert cfg_load together with en=1: the bit is discarded and fill=0.

Source files
------------

// File: rtl/seq_detect_prog_if.sv
// Bus interface for the programmable serial pattern detector.
// Carries the serial bit stream, the configuration load port and the
// detector results. The master side feeds bits and configuration; the
// slave side is the detector itself.
interface seq_detect_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               en;
    logic               in;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    modport master (
        output en, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  out, match_cnt, cfg_err
    );

    modport slave (
        input  en, in, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output out, match_cnt, cfg_err
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector.
// Shifts one bit per enabled cycle into a history register and compares
// the newest len bits against a runtime-loaded pattern. Produces a
// one-cycle registered match pulse and a saturating match counter.
// Out of reset it detects "0011" with overlapping matches, so it is a
// drop-in replacement for the old fixed detector.
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_0011,
    parameter int                 DEF_LEN     = 4
) (
    input  logic              clk,
    input  logic              clr,
    seq_detect_prog_if.slave  bus
);
    localparam int LW = $clog2(MAX_LEN + 1);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [MAX_LEN-1:0] r_hist;
    logic [LW-1:0]      r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LW-1:0]      r_len;
    logic               r_ovl;
    logic [0:0]         r_state;
    logic               r_out;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [LW-1:0]      w_fill_inc;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_hit;
    logic               w_len_ok;
    logic               w_cnt_full;

    assign w_hist_nxt = {r_hist[MAX_LEN-2:0], bus.in};
    assign w_len_ok   = (bus.cfg_len != {LW{1'b0}}) &&
                        (bus.cfg_len <= LW'(MAX_LEN));
    assign w_cnt_full = &r_cnt;

    // Next fill level, compare mask and match decision for the incoming bit.
    always_comb begin
        w_fill_inc = r_fill;
        w_mask     = {MAX_LEN{1'b0}};
        w_hit      = 1'b0;
        if (r_fill >= r_len) begin
            w_fill_inc = r_len;
        end else begin
            w_fill_inc = r_fill + LW'(1);
        end
        // Only the newest len bits take part in the comparison.
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
        if ((w_fill_inc == r_len) &&
            (((w_hist_nxt ^ r_pat) & w_mask) == {MAX_LEN{1'b0}})) begin
            w_hit = 1'b1;
        end else begin
            w_hit = 1'b0;
        end
    end

    // Configuration, history, match pulse and counter state.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_pat   <= DEF_PATTERN;
            r_len   <= LW'(DEF_LEN);
            r_ovl   <= 1'b1;
            r_hist  <= {MAX_LEN{1'b0}};
            r_fill  <= {LW{1'b0}};
            r_out   <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
            r_err   <= 1'b0;
            r_state <= ST_RUN;
        end else if (bus.cfg_load) begin
            // A load restarts detection; the bit presented this cycle is dropped.
            r_hist <= {MAX_LEN{1'b0}};
            r_fill <= {LW{1'b0}};
            r_out  <= 1'b0;
            r_cnt  <= {CNT_W{1'b0}};
            if (w_len_ok) begin
                r_pat   <= bus.cfg_pattern;
                r_len   <= bus.cfg_len;
                r_ovl   <= bus.cfg_overlap;
                r_err   <= 1'b0;
                r_state <= ST_RUN;
            end else begin
                // Illegal length: keep the old configuration but stop detecting.
                r_err   <= 1'b1;
                r_state <= ST_HALT;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.en) begin
                        r_hist <= w_hist_nxt;
                        if (w_hit) begin
                            r_out <= 1'b1;
                            if (!w_cnt_full) begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end else begin
                                r_cnt <= r_cnt;
                            end
                            // Non-overlapping mode needs len fresh bits after a match.
                            if (r_ovl) begin
                                r_fill <= w_fill_inc;
                            end else begin
                                r_fill <= {LW{1'b0}};
                            end
                        end else begin
                            r_out  <= 1'b0;
                            r_fill <= w_fill_inc;
                        end
                    end else begin
                        r_out <= 1'b0;
                    end
                end
                ST_HALT: begin
                    r_out <= 1'b0;
                end
                default: begin
                    r_out   <= 1'b0;
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign bus.out       = r_out;
    assign bus.match_cnt = r_cnt;
    assign bus.cfg_err   = r_err;
endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed testbench for seq_detect_prog. Main instance uses the default
// build; a second instance with a 2-bit counter exercises saturation.
module tb_seq_detect_prog;
    logic clk;
    logic clr;

    int n_total;
    int n_bad;

    seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(8)) bus  ();
    seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(2)) bus2 ();

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (
        .clk (clk),
        .clr (clr),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed one enabled bit to the main DUT and check the pulse.
    task automatic send(input logic b, input logic exp_out, input string tag);
        bus.en = 1'b1;
        bus.in = b;
        tick();
        bus.en = 1'b0;
        chk(tag, {31'd0, bus.out}, {31'd0, exp_out});
    endtask

    // One idle cycle on the main DUT; the pulse must be low.
    task automatic idle(input string tag);
        bus.en = 1'b0;
        bus.in = 1'b1;
        tick();
        chk(tag, {31'd0, bus.out}, 32'd0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        bus.cfg_load    = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ovl;
        tick();
        bus.cfg_load = 1'b0;
        chk("load_out", {31'd0, bus.out}, 32'd0);
        chk("load_cnt", {24'd0, bus.match_cnt}, 32'd0);
    endtask

    initial begin
        logic [5:0] s1;
        logic [5:0] e1;
        logic [4:0] s2;
        logic [4:0] e2;
        logic [4:0] e3;
        logic [4:0] s6;
        logic [4:0] e6;
        logic [2:0] c2;

        n_total = 0;
        n_bad   = 0;
        bus.en = 1'b0;  bus.in = 1'b0;  bus.cfg_load = 1'b0;
        bus.cfg_pattern = 8'd0;  bus.cfg_len = 4'd0;  bus.cfg_overlap = 1'b0;
        bus2.en = 1'b0; bus2.in = 1'b0; bus2.cfg_load = 1'b0;
        bus2.cfg_pattern = 8'd0; bus2.cfg_len = 4'd0; bus2.cfg_overlap = 1'b0;

        // Reset state
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        chk("rst_out", {31'd0, bus.out}, 32'd0);
        chk("rst_cnt", {24'd0, bus.match_cnt}, 32'd0);
        chk("rst_err", {31'd0, bus.cfg_err}, 32'd0);

        // Default 0011 detector: stream 1,0,0,1,1,0 (index 5 first)
        s1 = 6'b100110;
        e1 = 6'b000010;
        for (int i = 5; i >= 0; i--) send(s1[i], e1[i], "def_out");
        chk("def_cnt", {24'd0, bus.match_cnt}, 32'd1);
        chk("def_err", {31'd0, bus.cfg_err}, 32'd0);

        // Pattern 101, overlapping: pulses after bits 3 and 5
        load(8'b0000_0101, 4'd3, 1'b1);
        s2 = 5'b10101;
        e2 = 5'b00101;
        for (int i = 4; i >= 0; i--) send(s2[i], e2[i], "p101_ovl");
        chk("p101_ovl_cnt", {24'd0, bus.match_cnt}, 32'd2);

        // Same pattern non-overlapping: single pulse
        load(8'b0000_0101, 4'd3, 1'b0);
        e3 = 5'b00100;
        for (int i = 4; i >= 0; i--) send(s2[i], e3[i], "p101_novl");
        chk("p101_novl_cnt", {24'd0, bus.match_cnt}, 32'd1);

        // Default pattern with idle gaps between bits
        load(8'b0000_0011, 4'd4, 1'b1);
        send(1'b0, 1'b0, "gap_b0"); idle("gap_i0");
        send(1'b0, 1'b0, "gap_b1"); idle("gap_i1");
        send(1'b1, 1'b0, "gap_b2"); idle("gap_i2");
        send(1'b1, 1'b1, "gap_b3"); idle("gap_i3");
        chk("gap_cnt", {24'd0, bus.match_cnt}, 32'd1);

        // Illegal lengths halt the detector
        bus.cfg_load = 1'b1; bus.cfg_len = 4'd0; bus.cfg_pattern = 8'd1;
        tick();
        bus.cfg_load = 1'b0;
        chk("len0_err", {31'd0, bus.cfg_err}, 32'd1);
        send(1'b0, 1'b0, "halt0_a"); send(1'b0, 1'b0, "halt0_b");
        send(1'b1, 1'b0, "halt0_c"); send(1'b1, 1'b0, "halt0_d");
        bus.cfg_load = 1'b1; bus.cfg_len = 4'd9;
        tick();
        bus.cfg_load = 1'b0;
        chk("len9_err", {31'd0, bus.cfg_err}, 32'd1);
        send(1'b0, 1'b0, "halt9_a"); send(1'b0, 1'b0, "halt9_b");
        send(1'b1, 1'b0, "halt9_c"); send(1'b1, 1'b0, "halt9_d");
        chk("halt_cnt", {24'd0, bus.match_cnt}, 32'd0);

        // Legal len=1 pattern 1 recovers: back-to-back pulses
        load(8'b0000_0001, 4'd1, 1'b1);
        chk("len1_err", {31'd0, bus.cfg_err}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            send(1'b1, 1'b1, "len1_out");
            chk("len1_cnt", {24'd0, bus.match_cnt}, i);
        end

        // 2-bit counter saturation on the second instance
        bus2.cfg_load = 1'b1; bus2.cfg_pattern = 8'd0;
        bus2.cfg_len = 4'd1;  bus2.cfg_overlap = 1'b1;
        tick();
        bus2.cfg_load = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus2.en = 1'b1; bus2.in = 1'b0;
            tick();
            c2 = (i > 3) ? 3'd3 : 3'(i);
            chk("sat_out", {31'd0, bus2.out}, 32'd1);
            chk("sat_cnt", {30'd0, bus2.match_cnt}, {29'd0, c2});
        end
        bus2.en = 1'b0;

        // Reset mid-pattern loses the partial 0,0,1
        clr = 1'b1; tick(); clr = 1'b0;
        send(1'b0, 1'b0, "mid_a"); send(1'b0, 1'b0, "mid_b"); send(1'b1, 1'b0, "mid_c");
        clr = 1'b1; bus.en = 1'b1; bus.in = 1'b1;
        tick();
        clr = 1'b0; bus.en = 1'b0;
        chk("mid_rst_out", {31'd0, bus.out}, 32'd0);
        s6 = 5'b10011;
        e6 = 5'b00001;
        for (int i = 4; i >= 0; i--) send(s6[i], e6[i], "mid_out");
        chk("mid_cnt", {24'd0, bus.match_cnt}, 32'd1);

        // Load together with en=1: the presented bit is discarded
        bus.en = 1'b1; bus.in = 1'b0;
        load(8'b0000_0011, 4'd4, 1'b1);
        send(1'b0, 1'b0, "ld_en_a"); send(1'b1, 1'b0, "ld_en_b");
        send(1'b1, 1'b0, "ld_en_c");
        send(1'b0, 1'b0, "ld_en_d"); send(1'b0, 1'b0, "ld_en_e");
        send(1'b1, 1'b0, "ld_en_f"); send(1'b1, 1'b1, "ld_en_g");
        chk("ld_en_cnt", {24'd0, bus.match_cnt}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
